// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate/result encodings
// and the immediate-extension helper used by the ID stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluCtrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immSrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_e;

  // B and J offsets are halfword-aligned, so their bit 0 is always zero.
  function automatic logic [XLEN-1:0] immExtend(input logic [31:0] instr,
                                                 input immSrc_e     immSrc);
    logic [XLEN-1:0] imm;
    unique case (immSrc)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// 32x32 register file, two combinational read ports and one write port.
// Define DECODE_BYPASS_EN to make reads return same-cycle write data.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // x0 is hardwired to zero regardless of what the write port does.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) begin
`ifdef DECODE_BYPASS_EN
      if (we && wa == ra1) rd1 = wd;
      else                 rd1 = regs[ra1];
`else
      rd1 = regs[ra1];
`endif
    end
    if (ra2 != 5'd0) begin
`ifdef DECODE_BYPASS_EN
      if (we && wa == ra2) rd2 = wd;
      else                 rd2 = regs[ra2];
`else
      rd2 = regs[ra2];
`endif
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// ID stage: control decode, immediate extension, register read and the
// ID/EX pipeline register. DECODE_BYPASS_EN selects a write-first register file.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD;
  resultSrc_e      resultSrcD;
  aluCtrl_e        aluControlD;
  immSrc_e         immSrcD;
  logic [XLEN-1:0] rd1D, rd2D, immExtD;
  logic [6:0]      opcode;
  logic [2:0]      funct3;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) uRegFile (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .wa  (RdW),
    .wd  (ResultW),
    .rd1 (rd1D),
    .rd2 (rd2D)
  );

  // Unrecognised opcodes fall through to an all-zero nop bubble.
  always_comb begin
    regWriteD   = 1'b0;
    memWriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    resultSrcD  = RES_ALU;
    aluControlD = ALU_ADD;
    immSrcD     = IMM_I;
    unique case (opcode)
      OP_R, OP_I: begin
        regWriteD = 1'b1;
        aluSrcD   = (opcode == OP_I);
        case (funct3)
          3'b000:  aluControlD = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControlD = ALU_SLT;
          3'b110:  aluControlD = ALU_OR;
          3'b111:  aluControlD = ALU_AND;
          default: aluControlD = ALU_ADD;
        endcase
      end
      OP_LW: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = RES_MEM;
      end
      OP_SW: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immSrcD   = IMM_S;
      end
      OP_BEQ: begin
        branchD     = 1'b1;
        aluControlD = ALU_SUB;
        immSrcD     = IMM_B;
      end
      OP_JAL: begin
        jumpD      = 1'b1;
        regWriteD  = 1'b1;
        resultSrcD = RES_PC4;
        immSrcD    = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    immExtD = immExtend(InstrD, immSrcD);
  end

  // Flush wins over decode so the execute stage sees a clean bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= regWriteD;
      MemWriteE   <= memWriteD;
      JumpE       <= jumpD;
      BranchE     <= branchD;
      ALUSrcE     <= aluSrcD;
      ResultSrcE  <= resultSrcD;
      ALUControlE <= aluControlD;
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      ImmExtE     <= immExtD;
      RdE         <= InstrD[11:7];
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed, table-driven bench for the decode_cycle ID stage.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  ctrl;
    logic        checkImm;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[16];

`ifdef DECODE_BYPASS_EN
  localparam logic [31:0] BYPASS_EXP = 32'h0000_1234;
`else
  localparam logic [31:0] BYPASS_EXP = 32'h0000_0000;
`endif

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  function automatic logic anyEActive();
    return |{RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
             ALUControlE, RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E};
  endfunction

  function automatic logic [9:0] ctrlE();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic we, input logic [4:0] rd,
                               input logic [31:0] res, input logic flush);
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    FlushE    = flush;
    @(posedge clk);
    #1;
  endtask

  // R-type add x0, rs, rs: a convenient way to read one register on both ports.
  function automatic logic [31:0] readInstr(input logic [4:0] r);
    return {7'd0, r, r, 3'd0, 5'd0, 7'b0110011};
  endfunction

  initial begin
    logic [31:0] instr;
    logic        allClear;

    vecs[0]  = '{32'h002082B3, {5'b10000, 2'b00, 3'b000}, 1'b0, 32'h0};
    vecs[1]  = '{32'h40208333, {5'b10000, 2'b00, 3'b001}, 1'b0, 32'h0};
    vecs[2]  = '{32'h0020F3B3, {5'b10000, 2'b00, 3'b010}, 1'b0, 32'h0};
    vecs[3]  = '{32'h0020E433, {5'b10000, 2'b00, 3'b011}, 1'b0, 32'h0};
    vecs[4]  = '{32'h0020A4B3, {5'b10000, 2'b00, 3'b101}, 1'b0, 32'h0};
    vecs[5]  = '{32'h40008093, {5'b10001, 2'b00, 3'b000}, 1'b1, 32'h0000_0400};
    vecs[6]  = '{32'hFFF0F513, {5'b10001, 2'b00, 3'b010}, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{32'hFF812203, {5'b10001, 2'b01, 3'b000}, 1'b1, 32'hFFFF_FFF8};
    vecs[8]  = '{32'h008000EF, {5'b10100, 2'b10, 3'b000}, 1'b1, 32'h0000_0008};
    vecs[9]  = '{32'hFFDFF06F, {5'b10100, 2'b10, 3'b000}, 1'b1, 32'hFFFF_FFFC};
    vecs[10] = '{32'h123450B7, {5'b00000, 2'b00, 3'b000}, 1'b1, 32'h0000_0123};
    vecs[11] = '{32'h00000000, {5'b00000, 2'b00, 3'b000}, 1'b1, 32'h0000_0000};
    vecs[12] = '{32'hFE208EE3, {5'b00010, 2'b00, 3'b001}, 1'b1, 32'hFFFF_FFFC};
    vecs[13] = '{32'h0020A423, {5'b01001, 2'b00, 3'b000}, 1'b1, 32'h0000_0008};
    vecs[14] = '{32'hFFF12093, {5'b10001, 2'b00, 3'b101}, 1'b1, 32'hFFFF_FFFF};
    vecs[15] = '{32'h7FF06193, {5'b10001, 2'b00, 3'b011}, 1'b1, 32'h0000_07FF};

    rst = 1'b1;
    InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset state", {31'd0, anyEActive()}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5 at PC 0x10
    applyStimulus(32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("addi ctrl", {22'd0, ctrlE()}, {22'd0, 5'b10001, 2'b00, 3'b000});
    checkOutput("addi imm", ImmExtE, 32'd5);
    checkOutput("addi rd", {27'd0, RdE}, 32'd1);
    checkOutput("addi rd1", RD1E, 32'd0);
    checkOutput("addi pc", PCE, 32'h10);
    checkOutput("addi pc4", PCPlus4E, 32'h14);

    InstrD = 32'h0020A423;
    #1;
    checkOutput("rs1d/rs2d comb", {22'd0, Rs1D, Rs2D}, {22'd0, 5'd1, 5'd2});

    // Populate every register, then reset mid-cycle and expect everything cleared.
    for (int i = 1; i < 32; i++)
      applyStimulus(32'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
    applyStimulus(readInstr(5'd7), 32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("pre-reset x7", RD1E, 32'h107);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset clears E", {31'd0, anyEActive()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(32'h00500093, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("fresh decode after reset", {22'd0, ctrlE()}, {22'd0, 5'b10001, 2'b00, 3'b000});
    allClear = 1'b1;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(readInstr(5'(i)), 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
      if ((RD1E | RD2E) !== 32'd0) allClear = 1'b0;
    end
    checkOutput("regfile cleared by reset", {31'd0, allClear}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      instr = vecs[i].instr;
      applyStimulus(instr, 32'h100 + 32'(4 * i), 1'b0, 5'd0, 32'd0, 1'b0);
      checkOutput($sformatf("vec%0d ctrl", i), {22'd0, ctrlE()}, {22'd0, vecs[i].ctrl});
      if (vecs[i].checkImm)
        checkOutput($sformatf("vec%0d imm", i), ImmExtE, vecs[i].imm);
      checkOutput($sformatf("vec%0d regs", i), {17'd0, RdE, Rs1E, Rs2E},
                  {17'd0, instr[11:7], instr[19:15], instr[24:20]});
      checkOutput($sformatf("vec%0d pc", i), PCE, 32'h100 + 32'(4 * i));
      checkOutput($sformatf("vec%0d pc4", i), PCPlus4E, 32'h104 + 32'(4 * i));
    end

    // Writeback x2, then sw x2,8(x1) reads it on port 2.
    applyStimulus(32'd0, 32'h200, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0);
    applyStimulus(32'h0020A423, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("sw ctrl", {22'd0, ctrlE()}, {22'd0, 5'b01001, 2'b00, 3'b000});
    checkOutput("sw imm", ImmExtE, 32'd8);
    checkOutput("sw rd2", RD2E, 32'hDEADBEEF);

    applyStimulus(32'hFE208EE3, 32'h208, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("beq ctrl", {22'd0, ctrlE()}, {22'd0, 5'b00010, 2'b00, 3'b001});
    checkOutput("beq imm", ImmExtE, 32'hFFFFFFFC);
    checkOutput("beq rd2", RD2E, 32'hDEADBEEF);

    // Writes to x0 are dropped, including the same-cycle read path.
    applyStimulus(32'h00500093, 32'h20C, 1'b1, 5'd0, 32'h55, 1'b0);
    checkOutput("x0 same cycle", RD1E, 32'd0);
    applyStimulus(32'h00500093, 32'h210, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("x0 after write", RD1E, 32'd0);

    // add x1,x3,x3 while x3 is being written.
    applyStimulus(32'h003180B3, 32'h214, 1'b1, 5'd3, 32'h1234, 1'b0);
    checkOutput("bypass rd1", RD1E, BYPASS_EXP);
    checkOutput("bypass rd2", RD2E, BYPASS_EXP);
    applyStimulus(32'h003180B3, 32'h218, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("x3 next cycle", RD1E, 32'h1234);

    // Flush with a live addi and a concurrent writeback to x5.
    applyStimulus(32'h00500093, 32'h21C, 1'b1, 5'd5, 32'hCAFE, 1'b1);
    checkOutput("flush clears E", {31'd0, anyEActive()}, 32'd0);
    applyStimulus(32'h000280B3, 32'h220, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("write during flush", RD1E, 32'hCAFE);
    checkOutput("decode after flush", {31'd0, RegWriteE}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
